// File: rtl/store_aligner_pkg.sv
// Shared load/store unit encodings: store-select and load-select codes,
// the store aligner FSM state type, and a small decode helper.
package store_aligner_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int BE_W   = DATA_W / 8;

  // Store type select carried on st_sel; values 5-7 are reserved.
  typedef enum logic [2:0] {
    ST_SB  = 3'd0,
    ST_SH  = 3'd1,
    ST_SW  = 3'd2,
    ST_SWL = 3'd3,
    ST_SWR = 3'd4
  } st_sel_e;

  // Load type select used by the companion load extractor.
  typedef enum logic [2:0] {
    LD_LB  = 3'd0,
    LD_LH  = 3'd1,
    LD_LW  = 3'd2,
    LD_LBU = 3'd3,
    LD_LHU = 3'd4,
    LD_LWL = 3'd5,
    LD_LWR = 3'd6
  } ld_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // True for every store encoding that produces a memory write.
  function automatic logic is_store_sel(input logic [2:0] sel);
    return (sel <= 3'(ST_SWR));
  endfunction

endpackage

// File: rtl/store_align_comb.sv
// Combinational store alignment: turns register data and the low address
// bits into a word-lane write pattern and byte enables.
module store_align_comb
  import store_aligner_pkg::*;
(
  input  logic [2:0]        sel,
  input  logic [1:0]        a,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] wdata_p0,
  output logic [BE_W-1:0]   be_p0,
  output logic              ok_p0
);

  // Lane steering and byte-enable generation per store type.
  always_comb begin
    wdata_p0 = '0;
    be_p0    = '0;
    ok_p0    = is_store_sel(sel);
    case (sel)
      ST_SB: begin
        wdata_p0 = {4{data[7:0]}};
        be_p0    = 4'b0001 << a;
      end
      ST_SH: begin
        wdata_p0 = {2{data[15:0]}};
        be_p0    = a[1] ? 4'b1100 : 4'b0011;
      end
      ST_SW: begin
        wdata_p0 = data;
        be_p0    = 4'b1111;
      end
      ST_SWL: begin
        wdata_p0 = data >> {a, 3'b000};
        be_p0    = 4'b1111 >> a;
      end
      ST_SWR: begin
        // 3-a on two bits is simply ~a.
        wdata_p0 = data << {~a, 3'b000};
        be_p0    = 4'b1111 << ~a;
      end
      default: begin
        wdata_p0 = '0;
        be_p0    = '0;
      end
    endcase
  end

endmodule

// File: rtl/store_aligner.sv
// Store aligner: accepts stores, aligns them to a word-wide memory write
// and holds the request until the memory acknowledges it.
// Optional build macro STORE_ALIGN_CHECK_EN adds misalignment detection
// and the addr_err pulse output.
module store_aligner
  import store_aligner_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [2:0]        st_sel,
  input  logic [DATA_W-1:0] st_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic              mem_ack,
  output logic              st_done
`ifdef STORE_ALIGN_CHECK_EN
  ,
  output logic              addr_err
`endif
);

  state_t            state;
  logic [DATA_W-1:0] wdata_p0;
  logic [BE_W-1:0]   be_p0;
  logic              ok_p0;
  logic              misalign_p0;
  logic              accept_p0;
  logic              issue_p0;

  store_align_comb u_align (
    .sel      (st_sel),
    .a        (st_addr[1:0]),
    .data     (st_data),
    .wdata_p0 (wdata_p0),
    .be_p0    (be_p0),
    .ok_p0    (ok_p0)
  );

  // Handshake, misalignment detection and the decision to issue a write.
  always_comb begin
    st_ready  = (state == IDLE) | ((state == BUSY) & mem_ack);
    accept_p0 = st_valid & st_ready;
`ifdef STORE_ALIGN_CHECK_EN
    misalign_p0 = ((st_sel == 3'(ST_SH)) & st_addr[0]) |
                  ((st_sel == 3'(ST_SW)) & (st_addr[1:0] != 2'b00));
`else
    misalign_p0 = 1'b0;
`endif
    issue_p0  = accept_p0 & ok_p0 & ~misalign_p0;
  end

  // ---- stage p1: FSM and registered memory request / status pulses ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      st_done   <= 1'b0;
`ifdef STORE_ALIGN_CHECK_EN
      addr_err  <= 1'b0;
`endif
    end else begin
      st_done <= (state == BUSY) & mem_ack;
`ifdef STORE_ALIGN_CHECK_EN
      addr_err <= accept_p0 & misalign_p0;
`endif
      case (state)
        IDLE: begin
          if (issue_p0) begin
            state     <= BUSY;
            mem_req   <= 1'b1;
            mem_addr  <= {st_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= wdata_p0;
            mem_be    <= be_p0;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            if (issue_p0) begin
              // Back-to-back: the next request replaces the finished one.
              state     <= BUSY;
              mem_req   <= 1'b1;
              mem_addr  <= {st_addr[ADDR_W-1:2], 2'b00};
              mem_wdata <= wdata_p0;
              mem_be    <= be_p0;
            end else begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
